proc_seq: RTL and testbench
===========================

// Module: proc_seq
// PURPOSE
// Parametrised instruction sequencer for the processor core. Fetches instructions over
// a req/ack program-memory interface and owns the PC and return-address stack.
// Resolves flow control (JMP/JZ/JNZ/CALL/RET/HALT) locally using the ALU zero flag.
// Issues every other instruction to the execute unit (alu_mod) over a valid/ready handshake.
// PARAMETERS
// PC_WIDTH      8      program counter / imem address width
// OPCODE_WIDTH  6      opcode field width (instr word = {opcode, operand})
// OPERAND_WIDTH 8      operand field width; jump/call target = operand[PC_WIDTH-1:0]
// STACK_DEPTH   8      return-address stack entries (>=1)
// RESET_VECTOR  0      PC value after reset
// OP_JMP/OP_JZ/OP_JNZ/OP_CALL/OP_RET/OP_HALT  6'h30/6'h31/6'h32/6'h33/6'h34/6'h3F  flow opcodes
// PORTS
// clk             in   1                     clock, all logic on rising edge
// rst             in   1                     synchronous active-high reset
// imem_addr       out  PC_WIDTH              fetch address (= PC)
// imem_req        out  1                     fetch request
// imem_ack        in   1                     imem_data valid this cycle
// imem_data       in   OPCODE+OPERAND_WIDTH  fetched instruction
// zero_flag       in   1                     ALU zero flag, stable while in DECODE
// ex_valid        out  1                     instruction offered to execute unit
// ex_ready        in   1                     execute unit accepts
// ex_op           out  OPCODE_WIDTH          issued opcode
// ex_operand      out  OPERAND_WIDTH         issued operand
// stack_level     out  $clog2(STACK_DEPTH+1) entries on return stack
// halted          out  1                     in HALT state
// stack_overflow  out  1                     sticky: CALL with stack full
// stack_underflow out  1                     sticky: RET with stack empty
// BEHAVIOUR
// - Clock clk; reset rst, synchronous active-high; rst dominates every other input in any state.
// - Reset: PC=RESET_VECTOR, sp=0, state=FETCH; all outputs 0, imem_req=0 during the rst cycle.
// - FSM: FETCH -> DECODE -> {ISSUE | FETCH | HALT}; ISSUE -> FETCH.
// - FETCH: imem_req=1, imem_addr=PC. On imem_ack=1, latch imem_data, go to DECODE. Wait indefinitely otherwise.
// - DECODE: one cycle, imem_req=0.
//   JMP: PC<=target.
//   JZ: PC<=zero_flag ? target : PC+1.
//   JNZ: inverse of JZ.
//   CALL: if sp<STACK_DEPTH, push PC+1, PC<=target; else set stack_overflow and go to HALT.
//   RET: if sp>0, PC<=pop; else set stack_underflow and go to HALT.
//   HALT: go to HALT, PC unchanged.
//   Other opcodes: register ex_op/ex_operand, go to ISSUE.
//   Flow ops return to FETCH.
// - ISSUE: ex_valid=1, ex_op/ex_operand held stable. Transfer occurs on ex_valid&&ex_ready.
//   On transfer: PC<=PC+1, ex_valid=0 next cycle, go to FETCH. ex_valid never drops before transfer.
// - HALT: absorbing; imem_req=0, ex_valid=0, halted=1. Exit only via rst.
// - PC arithmetic is modulo 2^PC_WIDTH; PC+1 wraps silently (max -> 0).
// - Latency:
//   flow instruction = fetch wait + 1 DECODE cycle.
//   ALU instruction = fetch wait + 1 DECODE cycle + ISSUE wait (>=1 cycle).
// - Stack: registered array, sp counts 0..STACK_DEPTH; stack_level=sp.
//   Overflow/underflow never corrupt entries or sp.
// - Error flags are sticky until rst. rst in ISSUE drops ex_valid the next cycle; no transfer is counted.
// CONFIGURATION
// - PROC_SEQ_STEP_EN defined: adds input step (1 bit).
//   FETCH asserts imem_req only after a step=1 pulse is seen (one instruction per pulse).
//   A pulse arriving while busy is held pending; reset clears the pending pulse.
// - PROC_SEQ_STEP_EN undefined: port absent; FETCH requests immediately (free-running).
// TESTING
// - rst 2 cycles, then release -> imem_addr=0, imem_req=1 on the first post-reset cycle;
//   ex_valid=0, halted=0, stack_level=0.
// - mem[0]={6'h01,8'h05}, mem[1]=HALT, ex_ready=1, ack 1 cycle after req
//   -> one transfer with ex_op=1, ex_operand=5; then imem_addr=1, halted=1.
// - mem[0]=JZ 0x20 with zero_flag=1 -> next imem_addr=0x20; repeat with zero_flag=0 -> 0x01.
// - mem[0]=CALL 0x10, mem[0x10]=RET -> stack_level 1 after CALL, 0 after RET; next fetch addr 0x01.
// - STACK_DEPTH=2: CALL chain 0->0x10->0x20->0x30
//   -> third CALL sets stack_overflow=1, halted=1, stack_level=2. A RET at addr 0 sets stack_underflow.
// - ex_ready=0 for 5 cycles in ISSUE -> ex_valid=1, ex_op stable, imem_req=0, PC unchanged;
//   rst asserted on cycle 3 -> ex_valid=0, PC=0 next cycle.

Source files
------------

// File: rtl/proc_seq.sv
// proc_seq: instruction sequencer. Fetches over a req/ack program-memory port, and owns the PC
// and the return-address stack. JMP/JZ/JNZ/CALL/RET/HALT are resolved locally. Every other
// opcode is issued to the execute unit over a valid/ready handshake.
// Optional build macro PROC_SEQ_STEP_EN: adds a 'step' input. Each step pulse releases one
// instruction fetch. Without the macro the sequencer free-runs.
module proc_seq #(
  parameter int unsigned PC_WIDTH      = 8,
  parameter int unsigned OPCODE_WIDTH  = 6,
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned STACK_DEPTH   = 8,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(6'h30),
  parameter logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(6'h31),
  parameter logic [OPCODE_WIDTH-1:0] OP_JNZ  = OPCODE_WIDTH'(6'h32),
  parameter logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(6'h33),
  parameter logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(6'h34),
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'h3F)
) (
  input  logic                                  clk,
  input  logic                                  rst,
`ifdef PROC_SEQ_STEP_EN
  input  logic                                  step,
`endif
  output logic [PC_WIDTH-1:0]                   imem_addr,
  output logic                                  imem_req,
  input  logic                                  imem_ack,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_data,
  input  logic                                  zero_flag,
  output logic                                  ex_valid,
  input  logic                                  ex_ready,
  output logic [OPCODE_WIDTH-1:0]               ex_op,
  output logic [OPERAND_WIDTH-1:0]              ex_operand,
  output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_level,
  output logic                                  halted,
  output logic                                  stack_overflow,
  output logic                                  stack_underflow
);

  localparam int unsigned IW          = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned STACK_SLOTS = 1 << IDX_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [SP_W-1:0]            sp_q, sp_d;
  logic [IW-1:0]              instr_q, instr_d;
  logic [OPCODE_WIDTH-1:0]    ex_op_q, ex_op_d;
  logic [OPERAND_WIDTH-1:0]   ex_operand_q, ex_operand_d;
  logic                       ovf_q, ovf_d;
  logic                       unf_q, unf_d;
  logic                       req_q, req_d;
  logic                       valid_q, valid_d;
  logic                       halted_q, halted_d;
  logic                       fetch_go_d;
  logic                       push_en;

  logic [PC_WIDTH-1:0]        stack_mem [STACK_SLOTS];

  logic [OPCODE_WIDTH-1:0]    dec_op;
  logic [OPERAND_WIDTH-1:0]   dec_operand;
  logic [PC_WIDTH-1:0]        target;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [IDX_W-1:0]           push_idx;
  logic [IDX_W-1:0]           top_idx;
  logic                       fetch_done;

  // Instruction field split and PC/stack helpers (PC+1 wraps silently)
  assign dec_op      = instr_q[IW-1:OPERAND_WIDTH];
  assign dec_operand = instr_q[OPERAND_WIDTH-1:0];
  assign target      = PC_WIDTH'(dec_operand);
  assign pc_inc      = pc_q + 1'b1;
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - 1'b1);
  assign fetch_done  = (state_q == S_FETCH) && req_q && imem_ack;

`ifdef PROC_SEQ_STEP_EN
  logic pend_q, pend_d;

  // A step pulse is held pending until a fetch consumes it
  always_comb begin
    pend_d = pend_q;
    if (fetch_done) pend_d = 1'b0;
    if (step)       pend_d = 1'b1;
    fetch_go_d = pend_d;
  end

  // Pending step register; reset drops any pulse seen before it
  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`else
  // Free-running: FETCH always requests
  always_comb begin
    fetch_go_d = 1'b1;
  end
`endif

  // Next-state, PC, stack pointer and issue-payload logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    sp_d         = sp_q;
    instr_d      = instr_q;
    ex_op_d      = ex_op_q;
    ex_operand_d = ex_operand_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    push_en      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (dec_op)
          OP_JMP:  pc_d = target;
          OP_JZ:   pc_d = zero_flag ? target : pc_inc;
          OP_JNZ:  pc_d = zero_flag ? pc_inc : target;
          OP_CALL: begin
            if (sp_q != SP_FULL) begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
              pc_d    = target;
            end else begin
              ovf_d   = 1'b1;
              state_d = S_HALT;
            end
          end
          OP_RET: begin
            if (sp_q != '0) begin
              sp_d = sp_q - 1'b1;
              pc_d = stack_mem[top_idx];
            end else begin
              unf_d   = 1'b1;
              state_d = S_HALT;
            end
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            ex_op_d      = dec_op;
            ex_operand_d = dec_operand;
            state_d      = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (valid_q && ex_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    req_d    = (state_d == S_FETCH) && fetch_go_d;
    valid_d  = (state_d == S_ISSUE);
    halted_d = (state_d == S_HALT);
  end

  // State and registered-output flops; reset dominates all other inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_VECTOR;
      sp_q         <= '0;
      instr_q      <= '0;
      ex_op_q      <= '0;
      ex_operand_q <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      sp_q         <= sp_d;
      instr_q      <= instr_d;
      ex_op_q      <= ex_op_d;
      ex_operand_q <= ex_operand_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
    end
  end

  // Return-address stack storage; entries are only written by an accepted CALL
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack_mem[push_idx] <= pc_inc;
  end

  assign imem_addr       = pc_q;
  assign imem_req        = req_q;
  assign ex_valid        = valid_q;
  assign ex_op           = ex_op_q;
  assign ex_operand      = ex_operand_q;
  assign stack_level     = sp_q;
  assign halted          = halted_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_proc_seq.sv
// Bench for proc_seq: program memory model with ack one cycle after req, an issue monitor that
// collects transfers, and per-scenario tasks that check results against an expected queue.
module tb_proc_seq;

  localparam int unsigned PW  = 8;
  localparam int unsigned OW  = 6;
  localparam int unsigned DW  = 8;
  localparam int unsigned SD  = 2;
  localparam int unsigned SLW = $clog2(SD + 1);
  localparam int unsigned IW  = OW + DW;
  localparam logic [OW-1:0] OP_JMP  = 6'h30;
  localparam logic [OW-1:0] OP_JZ   = 6'h31;
  localparam logic [OW-1:0] OP_JNZ  = 6'h32;
  localparam logic [OW-1:0] OP_CALL = 6'h33;
  localparam logic [OW-1:0] OP_RET  = 6'h34;
  localparam logic [OW-1:0] OP_HALT = 6'h3F;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] operand;
  } ex_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [PW-1:0]  imem_addr;
  logic           imem_req;
  logic           imem_ack = 1'b0;
  logic [IW-1:0]  imem_data = '0;
  logic           zero_flag = 1'b0;
  logic           ex_valid;
  logic           ex_ready = 1'b1;
  logic [OW-1:0]  ex_op;
  logic [DW-1:0]  ex_operand;
  logic [SLW-1:0] stack_level;
  logic           halted;
  logic           stack_overflow;
  logic           stack_underflow;
`ifdef PROC_SEQ_STEP_EN
  logic           step = 1'b1;
`endif

  logic [IW-1:0]  mem [256];
  ex_t            exp_ex[$];
  ex_t            obs_ex[$];
  int             n_cmp = 0;
  int             n_mis = 0;

  proc_seq #(.PC_WIDTH(PW), .OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PROC_SEQ_STEP_EN
    .step(step),
`endif
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .zero_flag(zero_flag),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_op(ex_op),
    .ex_operand(ex_operand),
    .stack_level(stack_level),
    .halted(halted),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle ack pulse per request
  always @(posedge clk) begin
    if (rst) imem_ack <= 1'b0;
    else     imem_ack <= imem_req && !imem_ack;
    imem_data <= mem[imem_addr];
  end

  // Issue monitor: record every valid&&ready transfer
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) obs_ex.push_back({ex_op, ex_operand});
  end

  // Global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = {OP_HALT, 8'h00};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ex.delete();
    obs_ex.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (obs_ex.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ex_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fetch(input logic [PW-1:0] addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (imem_req && imem_addr == addr) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    ex_ready = 1'b1; zero_flag = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %b expected 0", ex_valid); end
    n_cmp++; if ({halted, stack_overflow, stack_underflow} !== 3'b000) begin
      n_mis++; $display("FAIL rst_flags: got %b expected 000", {halted, stack_overflow, stack_underflow}); end
    n_cmp++; if (imem_addr !== 8'h00) begin n_mis++; $display("FAIL rst_addr: got %0h expected 0", imem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_mis++; $display("FAIL post_rst_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 8'h00) begin n_mis++; $display("FAIL post_rst_addr: got %0h expected 0", imem_addr); end
    n_cmp++; if ({ex_valid, halted} !== 2'b00) begin n_mis++; $display("FAIL post_rst_valid_halt: got %b expected 00", {ex_valid, halted}); end
    n_cmp++; if (stack_level !== '0) begin n_mis++; $display("FAIL post_rst_level: got %0d expected 0", stack_level); end
  endtask

  task automatic test_alu_issue();
    bit ok;
    ex_t e, o;
    clear_mem();
    mem[0] = {6'h01, 8'h05};
    ex_ready = 1'b1;
    do_reset();
    exp_ex.push_back({6'h01, 8'h05});
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL alu_timeout: got no halt expected halt"); end
    n_cmp++; if (obs_ex.size() != exp_ex.size()) begin
      n_mis++; $display("FAIL alu_count: got %0d expected %0d", obs_ex.size(), exp_ex.size()); end
    while (exp_ex.size() > 0 && obs_ex.size() > 0) begin
      e = exp_ex.pop_front(); o = obs_ex.pop_front();
      n_cmp++; if (o !== e) begin n_mis++; $display("FAIL alu_payload: got %0h expected %0h", o, e); end
    end
    n_cmp++; if (imem_addr !== 8'h01) begin n_mis++; $display("FAIL alu_halt_addr: got %0h expected 1", imem_addr); end
    n_cmp++; if ({halted, ex_valid, imem_req} !== 3'b100) begin
      n_mis++; $display("FAIL alu_halt_state: got %b expected 100", {halted, ex_valid, imem_req}); end
  endtask

  task automatic test_cond_jump();
    logic [OW-1:0] ops  [5] = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_JMP};
    logic          zfs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [PW-1:0] tgts [5] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h40};
    logic [PW-1:0] exps [5] = '{8'h20, 8'h01, 8'h20, 8'h01, 8'h40};
    bit ok;
    for (int k = 0; k < 5; k++) begin
      clear_mem();
      mem[0] = {ops[k], tgts[k]};
      zero_flag = zfs[k];
      do_reset();
      wait_halt(40, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL jump_timeout_%0d: got no halt expected halt", k); end
      n_cmp++; if (imem_addr !== exps[k]) begin
        n_mis++; $display("FAIL jump_target_%0d: got %0h expected %0h", k, imem_addr, exps[k]); end
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    ex_t e, o;
    clear_mem();
    mem[0]     = {OP_JMP, 8'hFF};
    mem[8'hFF] = {6'h02, 8'hAA};
    ex_ready = 1'b1;
    do_reset();
    exp_ex.push_back({6'h02, 8'hAA});
    wait_xfers(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL wrap_timeout: got no transfer expected 1"); end
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      n_mis++; $display("FAIL wrap_addr: got req=%b addr=%0h expected req=1 addr=0", imem_req, imem_addr); end
    while (exp_ex.size() > 0 && obs_ex.size() > 0) begin
      e = exp_ex.pop_front(); o = obs_ex.pop_front();
      n_cmp++; if (o !== e) begin n_mis++; $display("FAIL wrap_payload: got %0h expected %0h", o, e); end
    end
  endtask

  task automatic test_call_ret();
    bit ok;
    clear_mem();
    mem[0]     = {OP_CALL, 8'h10};
    mem[8'h10] = {OP_RET, 8'h00};
    do_reset();
    wait_fetch(8'h10, 40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL call_timeout: got no fetch at 10 expected fetch"); end
    n_cmp++; if (stack_level !== 2'd1) begin n_mis++; $display("FAIL call_level: got %0d expected 1", stack_level); end
    wait_halt(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL ret_timeout: got no halt expected halt"); end
    n_cmp++; if (stack_level !== 2'd0) begin n_mis++; $display("FAIL ret_level: got %0d expected 0", stack_level); end
    n_cmp++; if (imem_addr !== 8'h01) begin n_mis++; $display("FAIL ret_addr: got %0h expected 1", imem_addr); end
    n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b00) begin
      n_mis++; $display("FAIL ret_flags: got %b expected 00", {stack_overflow, stack_underflow}); end
  endtask

  task automatic test_stack_errors();
    bit ok;
    clear_mem();
    mem[0]     = {OP_CALL, 8'h10};
    mem[8'h10] = {OP_CALL, 8'h20};
    mem[8'h20] = {OP_CALL, 8'h30};
    do_reset();
    wait_halt(80, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL ovf_timeout: got no halt expected halt"); end
    n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b10) begin
      n_mis++; $display("FAIL ovf_flags: got %b expected 10", {stack_overflow, stack_underflow}); end
    n_cmp++; if (stack_level !== 2'd2) begin n_mis++; $display("FAIL ovf_level: got %0d expected 2", stack_level); end
    n_cmp++; if (imem_addr !== 8'h20) begin n_mis++; $display("FAIL ovf_pc: got %0h expected 20", imem_addr); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({halted, stack_overflow, imem_req} !== 3'b110) begin
      n_mis++; $display("FAIL ovf_sticky: got %b expected 110", {halted, stack_overflow, imem_req}); end
    clear_mem();
    mem[0] = {OP_RET, 8'h00};
    do_reset();
    wait_halt(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL unf_timeout: got no halt expected halt"); end
    n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b01) begin
      n_mis++; $display("FAIL unf_flags: got %b expected 01", {stack_overflow, stack_underflow}); end
    n_cmp++; if ({stack_level, imem_addr} !== {2'd0, 8'h00}) begin
      n_mis++; $display("FAIL unf_state: got level=%0d pc=%0h expected level=0 pc=0", stack_level, imem_addr); end
  endtask

  task automatic test_issue_stall();
    bit ok;
    ex_t e, o;
    clear_mem();
    mem[0] = {6'h05, 8'h3C};
    ex_ready = 1'b0;
    do_reset();
    exp_ex.push_back({6'h05, 8'h3C});
    wait_valid(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL stall_timeout: got no ex_valid expected 1"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if ({ex_valid, imem_req, ex_op, imem_addr} !== {1'b1, 1'b0, 6'h05, 8'h00}) begin
        n_mis++; $display("FAIL stall_hold_%0d: got v=%b req=%b op=%0h pc=%0h expected v=1 req=0 op=5 pc=0",
                          c, ex_valid, imem_req, ex_op, imem_addr); end
    end
    ex_ready = 1'b1;
    wait_halt(40, ok);
    n_cmp++; if (!ok || obs_ex.size() != 1) begin
      n_mis++; $display("FAIL stall_release: got halt=%b xfers=%0d expected halt=1 xfers=1", ok, obs_ex.size()); end
    while (exp_ex.size() > 0 && obs_ex.size() > 0) begin
      e = exp_ex.pop_front(); o = obs_ex.pop_front();
      n_cmp++; if (o !== e) begin n_mis++; $display("FAIL stall_payload: got %0h expected %0h", o, e); end
    end
    // Reset while stalled in ISSUE
    ex_ready = 1'b0;
    do_reset();
    wait_valid(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL rst_issue_timeout: got no ex_valid expected 1"); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({ex_valid, imem_addr, halted} !== {1'b0, 8'h00, 1'b0}) begin
      n_mis++; $display("FAIL rst_issue: got v=%b pc=%0h halt=%b expected v=0 pc=0 halt=0", ex_valid, imem_addr, halted); end
    n_cmp++; if (obs_ex.size() != 0) begin n_mis++; $display("FAIL rst_issue_xfer: got %0d expected 0", obs_ex.size()); end
    rst = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    ex_t e, o;
    ex_t prog [4];
    clear_mem();
    for (int i = 0; i < 4; i++) begin
      prog[i].op      = OW'($urandom_range(0, 'h2F));
      prog[i].operand = DW'($urandom);
      mem[i] = prog[i];
    end
    ex_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) exp_ex.push_back(prog[i]);
    wait_halt(150, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL b2b_timeout: got no halt expected halt"); end
    n_cmp++; if (obs_ex.size() != exp_ex.size()) begin
      n_mis++; $display("FAIL b2b_count: got %0d expected %0d", obs_ex.size(), exp_ex.size()); end
    while (exp_ex.size() > 0 && obs_ex.size() > 0) begin
      e = exp_ex.pop_front(); o = obs_ex.pop_front();
      n_cmp++; if (o !== e) begin n_mis++; $display("FAIL b2b_payload: got %0h expected %0h", o, e); end
    end
    n_cmp++; if (imem_addr !== 8'h04) begin n_mis++; $display("FAIL b2b_addr: got %0h expected 4", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_alu_issue();
    test_cond_jump();
    test_pc_wrap();
    test_call_ret();
    test_stack_errors();
    test_issue_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
